vga_fb_ctrl: RTL and testbench
==============================

Name: vga_fb_ctrl

Overview:
- Memory-mapped framebuffer stage that sits directly upstream of the VGA colour/sync output pins.
- The CPU writes 12-bit RGB pixels over the data bus into a 160x100 framebuffer.
- The video side reads that framebuffer using h/v counters from the VGA timing stage and emits pixel-aligned RGB plus delayed syncs. Each framebuffer pixel is shown as a 4x4 block on the 640x400 active area.
- Includes a hardware fill engine that clears the screen to one colour.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 100, framebuffer height in pixels
- SCALE_SHIFT, 2, log2 of the pixel replication factor (4x4)
- REG_BASE, 16'h3F00, word address of the register block

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  one-clk pulse per VGA pixel, from the timing stage
- h_cnt  in  10  horizontal pixel counter, from the timing stage
- v_cnt  in  10  vertical line counter, from the timing stage
- hs_in  in  1  horizontal sync, from the timing stage
- vs_in  in  1  vertical sync, from the timing stage
- bus_addr  in  16  word address
- bus_wdata  in  32  write data
- bus_we  in  1  write strobe
- bus_re  in  1  read strobe
- bus_rdata  out  32  read data
- bus_ready  out  1  access accepted this cycle
- vga_r  out  4  red output
- vga_g  out  4  green output
- vga_b  out  4  blue output
- vga_hs  out  1  delayed horizontal sync
- vga_vs  out  1  delayed vertical sync

Behaviour:
- Interface decision: one clock, clk; reset_n is asynchronous and active-low.
- Reset values:
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 0, bus_rdata = 0.
  - CTRL = 0, FILL_COLOR = 0, fill FSM = IDLE.
  - bus_ready is combinational and equals 1 while the FSM is IDLE.
- Memory map (word addresses):
  - 0..FB_W*FB_H-1 = pixel RAM, data bits [11:0] = {R,G,B}.
  - REG_BASE+0 = CTRL: bit0 display enable; writing bit1=1 starts a fill (self-clearing).
  - REG_BASE+1 = FILL_COLOR[11:0].
  - REG_BASE+2 = STATUS: bit0 = fill busy (read-only).
- Bus rules:
  - Accesses complete in the cycle where strobe && bus_ready are both high.
  - bus_rdata is registered and valid the cycle after the read is accepted.
  - Reads of pixel RAM return 0.
  - Addresses in the unmapped gap (16000..REG_BASE-1, and above REG_BASE+2) read 0, writes are dropped, and bus_ready is still 1.
  - Writes to STATUS are ignored.
- Fill FSM:
  - IDLE -> FILL when CTRL bit1 is written as 1.
  - In FILL, writes FILL_COLOR to address fill_ptr once per clk; fill_ptr counts 0..FB_W*FB_H-1.
  - FILL -> IDLE after the last address is written (16000 cycles).
  - During FILL, CPU pixel-RAM writes hold bus_ready=0 (stall) until IDLE. Register accesses still complete, with bus_ready=1.
  - A start request during FILL is ignored.
- Video pipeline (advances only on pix_en):
  - Stage 0 registers active = (h_cnt<640 && v_cnt<400) and rd_addr = (v_cnt>>SCALE_SHIFT)*FB_W + (h_cnt>>SCALE_SHIFT). Multiplication is by constant.
  - Stage 1 registers the RAM read data.
  - Stage 2 drives RGB = (active_d2 && CTRL.en) ? data : 0.
  - hs_in/vs_in pass through a 2-stage pix_en-qualified shift register, so syncs stay aligned with RGB. Latency is 2 pix_en ticks.
- Write/read collision:
  - The RAM is simple dual-port (one write port, one read port).
  - A read of the address being written returns old data.
- Reset mid-fill: the FSM returns to IDLE, STATUS.busy=0, and RAM contents are undefined (not cleared).

Optional Feature:
- Macro name: VGA_BORDER_EN.
- When defined: stage 2 forces RGB=12'hF00 on active pixels where h=0, h=639, v=0 or v=399, using the stage-0-registered coordinates. This applies only when CTRL.en=1 and is independent of RAM contents.
- When undefined: no border logic; RGB comes purely from RAM.

Decomposition:
- Shared package vga_pkg:
  - Active area constants: ACT_W=640, ACT_H=400.
  - Register offsets: CTRL/FILL_COLOR/STATUS.
  - Fill FSM state enum (IDLE, FILL).
  - RGB12 typedef.
- Sub-module vga_fb_ram:
  - Parameterised-depth simple dual-port RAM, 12 bits wide.
  - Registered read output; inferable as block RAM.

Test Plan:
1. Reset release: with reset_n held low, all outputs are 0 (vga_hs=1); write CTRL=1, then pixel 0 = 12'h0F0 -> h/v=(0..3,0..3) shows RGB 0,F,0 exactly 2 pix_en ticks after the counters, with hs/vs delayed equally.
2. Scaling: write pixel 161 = 12'h00F -> h=4..7, v=4..7 output blue, and h=8 returns to the neighbouring pixel's value.
3. Fill: FILL_COLOR=12'hFFF, start fill -> STATUS.busy=1 for 16000 clks. A CPU pixel write issued at cycle 100 stalls until busy=0, then lands. The whole screen reads white except that pixel.
4. Enable off: with CTRL.en=0, RGB=0 for the whole frame while syncs keep toggling.
5. Reset mid-fill: assert reset_n low at cycle 5000 -> STATUS=0 and FSM IDLE after release; a new fill completes in 16000 clks.
6. Border: with VGA_BORDER_EN defined, h=0 or v=399 outputs F,0,0 regardless of RAM; without the macro, the RAM value is output.

Source files
------------

// File: rtl/vga_fb_ctrl_pkg.sv
// vga_pkg: shared constants, register offsets, fill FSM states and pixel type for vga_fb_ctrl.
package vga_pkg;
   localparam int ACT_W = 640;
   localparam int ACT_H = 400;
   localparam logic [15:0] OFS_CTRL   = 16'd0;
   localparam logic [15:0] OFS_FILL   = 16'd1;
   localparam logic [15:0] OFS_STATUS = 16'd2;
   typedef enum logic {IDLE, FILL} fill_st_e;
   typedef logic [11:0] rgb12_t;
endpackage

// File: rtl/vga_fb_ctrl_if.sv
// vga_fb_ctrl_if: CPU word bus into the framebuffer controller.
interface vga_fb_ctrl_if;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   modport master (output bus_addr, bus_wdata, bus_we, bus_re, input bus_rdata, bus_ready);
   modport slave  (input bus_addr, bus_wdata, bus_we, bus_re, output bus_rdata, bus_ready);
endinterface

// File: rtl/vga_fb_ctrl_ram.sv
// vga_fb_ram: simple dual-port 12-bit RAM with registered read; read-during-write returns old data.
module vga_fb_ram
   import vga_pkg::*;
#(
   parameter int DEPTH = 16000,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  rgb12_t        wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output rgb12_t        rdata_o
);
   rgb12_t mem [DEPTH];
   rgb12_t rdata_q;
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: CPU-writable 160x100 framebuffer scaled 4x onto 640x400 VGA, with a clear-screen fill engine.
// Optional macro VGA_BORDER_EN paints a red frame around the active area when display is enabled.
module vga_fb_ctrl
   import vga_pkg::*;
#(
   parameter int          FB_W        = 160,
   parameter int          FB_H        = 100,
   parameter int          SCALE_SHIFT = 2,
   parameter logic [15:0] REG_BASE    = 16'h3F00
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pix_en,
   input  logic [9:0]          h_cnt,
   input  logic [9:0]          v_cnt,
   input  logic                hs_in,
   input  logic                vs_in,
   vga_fb_ctrl_if.slave        bus,
   output logic [3:0]          vga_r,
   output logic [3:0]          vga_g,
   output logic [3:0]          vga_b,
   output logic                vga_hs,
   output logic                vga_vs
);
   localparam int DEPTH = FB_W * FB_H;
   localparam int AW    = $clog2(DEPTH);

   fill_st_e      st_q, st_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          en_q;
   rgb12_t        col_q;
   logic [31:0]   rdata_q, rd_mux;
   logic          is_pix, is_ctrl, is_col, is_stat, acc_wr, acc_rd, filling;
   logic          ram_we;
   logic [AW-1:0] ram_waddr, rd_addr;
   rgb12_t        ram_wdata, ram_rdata, rgb_q;
   logic          act_q, bord_q, bord_c;
   logic [1:0]    hs_q, vs_q;
   logic          unused_bits;

   assign filling = (st_q == FILL);
   assign is_pix  = bus.bus_addr < 16'(DEPTH);
   assign is_ctrl = bus.bus_addr == REG_BASE + OFS_CTRL;
   assign is_col  = bus.bus_addr == REG_BASE + OFS_FILL;
   assign is_stat = bus.bus_addr == REG_BASE + OFS_STATUS;
   // Only pixel writes contend with the fill engine for the RAM write port.
   assign bus.bus_ready = !filling || !(bus.bus_we && is_pix);
   assign acc_wr = bus.bus_we && bus.bus_ready;
   assign acc_rd = bus.bus_re && bus.bus_ready;
   assign rd_mux = is_ctrl ? {31'b0, en_q} : is_col ? {20'b0, col_q} : is_stat ? {31'b0, filling} : 32'b0;
   assign bus.bus_rdata = rdata_q;
   assign unused_bits = ^bus.bus_wdata[31:12];

   always_comb begin
      st_d  = st_q;
      ptr_d = ptr_q;
      if (!filling) begin
         if (acc_wr && is_ctrl && bus.bus_wdata[1]) begin
            st_d  = FILL;
            ptr_d = '0;
         end
      end else begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == AW'(DEPTH - 1)) st_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q    <= IDLE;
         ptr_q   <= '0;
         en_q    <= 1'b0;
         col_q   <= '0;
         rdata_q <= '0;
      end else begin
         st_q    <= st_d;
         ptr_q   <= ptr_d;
         en_q    <= (acc_wr && is_ctrl) ? bus.bus_wdata[0] : en_q;
         col_q   <= (acc_wr && is_col) ? bus.bus_wdata[11:0] : col_q;
         rdata_q <= acc_rd ? rd_mux : rdata_q;
      end
   end

   assign ram_we    = filling || (acc_wr && is_pix);
   assign ram_waddr = filling ? ptr_q : bus.bus_addr[AW-1:0];
   assign ram_wdata = filling ? col_q : bus.bus_wdata[11:0];
   assign rd_addr   = AW'((v_cnt >> SCALE_SHIFT) * FB_W + (h_cnt >> SCALE_SHIFT));
`ifdef VGA_BORDER_EN
   assign bord_c = (h_cnt == 10'd0) || (h_cnt == 10'(ACT_W - 1)) || (v_cnt == 10'd0) || (v_cnt == 10'(ACT_H - 1));
`else
   assign bord_c = 1'b0;
`endif

   // The block RAM's own address register acts as the stage-0 rd_addr register.
   vga_fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (pix_en),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_q  <= 1'b0;
         bord_q <= 1'b0;
         rgb_q  <= '0;
         hs_q   <= 2'b11;
         vs_q   <= 2'b00;
      end else if (pix_en) begin
         act_q  <= (h_cnt < 10'(ACT_W)) && (v_cnt < 10'(ACT_H));
         bord_q <= bord_c;
         rgb_q  <= (act_q && en_q) ? (bord_q ? 12'hF00 : ram_rdata) : 12'h000;
         hs_q   <= {hs_q[0], hs_in};
         vs_q   <= {vs_q[0], vs_in};
      end
   end

   assign {vga_r, vga_g, vga_b} = rgb_q;
   assign vga_hs = hs_q[1];
   assign vga_vs = vs_q[1];
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: scoreboard bench for vga_fb_ctrl; honours VGA_BORDER_EN in its pixel model.
module tb_vga_fb_ctrl;
   import vga_pkg::*;
   localparam int DEPTH = 16000;
   localparam logic [15:0] CTRL = 16'h3F00, FCOL = 16'h3F01, STAT = 16'h3F02;

   logic clk = 0, reset_n = 0, pix_en = 0, hs_in = 1, vs_in = 0;
   logic [9:0] h_cnt = 0, v_cnt = 0;
   logic [3:0] vga_r, vga_g, vga_b;
   logic vga_hs, vga_vs;
   int total = 0, bad = 0, cyc = 0;
   logic [11:0] fb [DEPTH];
   logic en_m = 0;
   logic [13:0] exp_q[$];
   logic [31:0] rd;
   int ta, t0, tp;

   vga_fb_ctrl_if bus_if();

   vga_fb_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pix_en  (pix_en),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .hs_in   (hs_in),
      .vs_in   (vs_in),
      .bus     (bus_if),
      .vga_r   (vga_r),
      .vga_g   (vga_g),
      .vga_b   (vga_b),
      .vga_hs  (vga_hs),
      .vga_vs  (vga_vs)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, output int t);
      int n = 0;
      bus_if.bus_addr = a; bus_if.bus_wdata = d; bus_if.bus_we = 1; #1;
      while (!bus_if.bus_ready && n < 20000) begin @(negedge clk); #1; n++; end
      if (!bus_if.bus_ready) check("wr_timeout", 0, 1);
      t = cyc;
      @(negedge clk); bus_if.bus_we = 0;
      if (a < 16'(DEPTH)) fb[a] = d[11:0];
      else if (a == CTRL) en_m = d[0];
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
      int n = 0;
      bus_if.bus_addr = a; bus_if.bus_re = 1; #1;
      while (!bus_if.bus_ready && n < 20000) begin @(negedge clk); #1; n++; end
      if (!bus_if.bus_ready) check("rd_timeout", 0, 1);
      @(negedge clk); bus_if.bus_re = 0; d = bus_if.bus_rdata;
   endtask

   task automatic tick(input string tag, input int h, input int v);
      logic hs, vs, bd;
      logic [11:0] px;
      logic [13:0] e;
      hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
`ifdef VGA_BORDER_EN
      bd = (h == 0) || (h == 639) || (v == 0) || (v == 399);
`else
      bd = 0;
`endif
      px = 12'h000;
      if (h < 640 && v < 400 && en_m) px = bd ? 12'hF00 : fb[(v / 4) * 160 + h / 4];
      h_cnt = 10'(h); v_cnt = 10'(v); hs_in = hs; vs_in = vs; pix_en = 1;
      exp_q.push_back({px, hs, vs});
      @(negedge clk); pix_en = 0;
      @(negedge clk);
      if (exp_q.size() == 2) begin
         e = exp_q.pop_front();
         check(tag, {18'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'b0, e});
      end
   endtask

   task automatic scan_end(input string tag);
      tick(tag, 700, 450);
      exp_q.delete();
   endtask

   initial begin
      bus_if.bus_addr = 0; bus_if.bus_wdata = 0; bus_if.bus_we = 0; bus_if.bus_re = 0;
      repeat (3) @(negedge clk);
      check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 0);
      check("rst_rdata", bus_if.bus_rdata, 0);
      check("rst_ready", bus_if.bus_ready, 1);
      reset_n = 1;
      @(negedge clk);
      bus_rd(CTRL, rd); check("rst_ctrl", rd, 0);
      bus_rd(FCOL, rd); check("rst_fcol", rd, 0);
      bus_rd(STAT, rd); check("rst_stat", rd, 0);

      // display on, a 3x2 patch of pixels
      bus_wr(CTRL, 1, ta);
      bus_wr(0, 12'h0F0, ta); bus_wr(1, 12'h123, ta); bus_wr(2, 12'h456, ta);
      bus_wr(160, 12'h789, ta); bus_wr(161, 12'h00F, ta); bus_wr(162, 12'hABC, ta);
      bus_rd(CTRL, rd); check("ctrl_rd", rd, 1);
      bus_rd(0, rd); check("pix_rd_zero", rd, 0);
      bus_wr(16'd16000, 32'hFFF, ta);
      bus_rd(16'd16000, rd); check("gap_rd", rd, 0);
      bus_rd(16'h3F03, rd); check("above_rd", rd, 0);
      bus_wr(STAT, 1, ta);
      bus_rd(STAT, rd); check("stat_ro", rd, 0);
      bus_wr(FCOL, 12'hABC, ta);
      bus_rd(FCOL, rd); check("fcol_rd", rd, 12'hABC);
      for (int v = 0; v < 8; v++)
         for (int h = 0; h < 12; h++) tick("scale", h, v);
      tick("inact_h", 640, 0); tick("inact_v", 3, 400); tick("scale", 5, 5);
      scan_end("scale");

      // fill with a stalled pixel write
      bus_wr(FCOL, 12'hFFF, ta);
      bus_wr(CTRL, 3, ta);
      t0 = ta + 1;
      for (int i = 0; i < DEPTH; i++) fb[i] = 12'hFFF;
      while (cyc < t0 + 100) @(negedge clk);
      bus_rd(STAT, rd); check("busy", rd, 1);
      bus_rd(FCOL, rd); check("fcol_busy", rd, 12'hFFF);
      bus_wr(CTRL, 3, ta);
      bus_wr(16'd5000, 12'h0A5, tp);
      check("stall_len", tp - t0, 16000);
      bus_rd(STAT, rd); check("done", rd, 0);
      tick("fill", 161, 125); tick("fill", 163, 127); tick("fill", 164, 125); tick("fill", 159, 124);
      for (int i = 0; i < 200; i++) tick("fill", $urandom_range(0, 799), $urandom_range(0, 524));
      scan_end("fill");

      // display disabled
      bus_wr(CTRL, 0, ta);
      for (int i = 0; i < 150; i++) tick("en_off", $urandom_range(0, 799), $urandom_range(0, 524));
      scan_end("en_off");

      // reset in the middle of a fill
      bus_wr(CTRL, 3, ta);
      t0 = ta + 1;
      while (cyc < t0 + 5000) @(negedge clk);
      reset_n = 0; en_m = 0;
      @(negedge clk);
      check("mid_rst_hs", vga_hs, 1);
      reset_n = 1;
      @(negedge clk);
      check("mid_rst_ready", bus_if.bus_ready, 1);
      bus_rd(STAT, rd); check("mid_rst_stat", rd, 0);
      bus_rd(CTRL, rd); check("mid_rst_ctrl", rd, 0);
      bus_wr(FCOL, 12'h0C3, ta);
      bus_wr(CTRL, 3, ta);
      t0 = ta + 1;
      for (int i = 0; i < DEPTH; i++) fb[i] = 12'h0C3;
      bus_wr(16'd321, 12'h5A5, tp);
      check("refill_len", tp - t0, 16000);

      // edges of the active area
      for (int i = 0; i < 20; i++) begin
         tick("border", 0, i * 19); tick("border", 639, i * 19);
         tick("border", i * 31, 0); tick("border", i * 31, 399);
         tick("border", 1 + i * 30, 1 + i * 19);
      end
      tick("border", 640, 399); tick("border", 0, 400); tick("border", 4, 8); tick("border", 5, 9);
      scan_end("border");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
